// File: rtl/stream_wr_pkg.sv
// stream_wr_pkg: FSM states, AXI response code, beat size and burst-alignment helper shared by the burst writer.
package stream_wr_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, ADDR, DATA, RESP} state_e;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int BEAT_BYTES = 8;
  function automatic int burst_shift(input int burst_len);
    return $clog2(burst_len * BEAT_BYTES);
  endfunction
endpackage

// File: rtl/stream_burst_addr_gen.sv
// stream_burst_addr_gen: burst address and burst counter; load latches an aligned base and a burst count,
// step advances one burst, rewind restarts at the latched base; last_burst flags the final burst of a frame.
module stream_burst_addr_gen
  import stream_wr_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 20
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              rewind,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] addr,
  output logic              last_burst
);
  localparam int SH = burst_shift(BURST_LEN);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN * BEAT_BYTES);
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [CNT_W-1:0] total_q, total_d, cnt_q, cnt_d;
  always_comb begin
    base_d  = load ? (base >> SH) << SH : base_q;
    total_d = load ? count : total_q;
    addr_d  = load ? base_d : rewind ? base_q : step ? addr_q + STEP : addr_q;
    cnt_d   = (load || rewind) ? '0 : step ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge fclk) begin
    if (rst) begin
      base_q  <= '0;
      total_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      base_q  <= base_d;
      total_q <= total_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign addr       = addr_q;
  assign last_burst = cnt_q == total_q - CNT_W'(1);
endmodule

// File: rtl/stream_burst_writer.sv
// stream_burst_writer: drains a FWFT FIFO into aligned fixed-length AXI3 write bursts, one at a time.
// Control: start/stop/cont, base_addr, frame_bursts. FIFO side: din/din_valid/din_ready/burst_valid.
// AXI side: AW (addr/len/valid/ready), W (data/strb/last/valid/ready), B (resp/valid/ready).
// Status: busy, frame_done pulse, sticky err.
module stream_burst_writer
  import stream_wr_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 20
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              cont,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  frame_bursts,
  input  logic [63:0]       din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              burst_valid,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [3:0]        m_awlen,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [63:0]       m_wdata,
  output logic [7:0]        m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);
  state_e state_q, state_d;
  logic stop_q, stop_d, cont_q, cont_d, err_q, err_d;
  logic [3:0] beat_q, beat_d;
  logic w_hs, last_beat, stop_now, load, step, rewind, last_burst;
  stream_burst_addr_gen #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)) u_addr (
    .fclk       (fclk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .rewind     (rewind),
    .base       (base_addr),
    .count      (frame_bursts),
    .addr       (m_awaddr),
    .last_burst (last_burst)
  );
  assign m_awvalid  = state_q == ADDR;
  assign m_wvalid   = state_q == DATA && din_valid;
  assign din_ready  = state_q == DATA && m_wready;
  assign m_wlast    = state_q == DATA && last_beat;
  assign m_bready   = state_q == RESP;
  assign busy       = state_q != IDLE;
  assign frame_done = step && last_burst;
  assign err        = err_q;
  assign m_awlen    = 4'(BURST_LEN - 1);
  assign m_wstrb    = 8'hFF;
  assign m_wdata    = din;
  always_comb begin
    stop_now  = stop_q || stop;
    w_hs      = m_wvalid && m_wready;
    last_beat = beat_q == 4'(BURST_LEN - 1);
    load      = state_q == IDLE && start;
    step      = state_q == RESP && m_bvalid;
    // continuous mode rewinds at the frame end unless a stop is waiting to be honoured
    rewind    = step && last_burst && cont_q && !stop_now;
    cont_d    = load ? cont : cont_q;
    err_d     = load ? 1'b0 : (step && m_bresp != AXI_RESP_OKAY) ? 1'b1 : err_q;
    beat_d    = w_hs ? (last_beat ? 4'd0 : beat_q + 4'd1) : beat_q;
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = start ? WAIT : IDLE;
      WAIT:    state_d = stop_now ? IDLE : burst_valid ? ADDR : WAIT;
      ADDR:    state_d = m_awready ? DATA : ADDR;
      DATA:    state_d = (w_hs && last_beat) ? RESP : DATA;
      RESP:    state_d = !m_bvalid ? RESP : (!last_burst || rewind) ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
    // stop is only remembered while active and is forgotten on the way back to IDLE
    stop_d = (state_q == IDLE || state_d == IDLE) ? 1'b0 : stop_now;
  end
  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q <= IDLE;
      stop_q  <= 1'b0;
      cont_q  <= 1'b0;
      err_q   <= 1'b0;
      beat_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      cont_q  <= cont_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
    end
  end
endmodule

// File: tb/tb_stream_burst_writer.sv
// tb_stream_burst_writer: randomized FIFO/AXI-slave environment with a queue-based reference model.
module tb_stream_burst_writer;
  logic fclk = 0, rst = 1, start = 0, stop = 0, cont = 0;
  logic [31:0] base_addr = 0;
  logic [19:0] frame_bursts = 1;
  logic [63:0] din = 0;
  logic din_valid = 0, din_ready, burst_valid = 0;
  logic [31:0] m_awaddr;
  logic [3:0] m_awlen;
  logic m_awvalid, m_awready = 0;
  logic [63:0] m_wdata;
  logic [7:0] m_wstrb;
  logic m_wlast, m_wvalid, m_wready = 0;
  logic [1:0] m_bresp = 0;
  logic m_bvalid = 0, m_bready, busy, frame_done, err;

  stream_burst_writer dut (
    .fclk(fclk), .rst(rst), .start(start), .stop(stop), .cont(cont),
    .base_addr(base_addr), .frame_bursts(frame_bursts),
    .din(din), .din_valid(din_valid), .din_ready(din_ready), .burst_valid(burst_valid),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 fclk = ~fclk;

  int total = 0, bad = 0;
  logic [63:0] fifo[$], exp_w[$];
  int aw_cnt, w_cnt, b_cnt, fd_cnt, drop, bad_b = -1, mfb = 1;
  bit stall, drop_arm, b_pend, hold_aw, hold_w, chk_fall, fd_prev;
  logic [31:0] mbase, h_addr, first_aw;
  logic [63:0] h_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic upd_in();
    din_valid   = fifo.size() > 0 && drop == 0;
    din         = fifo.size() > 0 ? fifo[0] : '0;
    burst_valid = fifo.size() >= 16;
  endtask

  task automatic clr();
    fifo.delete();
    exp_w.delete();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; fd_cnt = 0; drop = 0; bad_b = -1;
    stall = 0; drop_arm = 0; b_pend = 0; hold_aw = 0; hold_w = 0; chk_fall = 0; fd_prev = 0;
    m_bvalid = 0; m_bresp = 0; m_awready = 1; m_wready = 1;
    upd_in();
  endtask

  task automatic fill(input int n);
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      fifo.push_back(w);
      exp_w.push_back(w);
    end
    upd_in();
  endtask

  // one clock: observe handshakes at the falling edge, respond just after the rising edge
  task automatic cycle();
    bit aw_hs, w_hs, wl_hs, b_hs, pop;
    @(negedge fclk);
    aw_hs = m_awvalid && m_awready;
    w_hs  = m_wvalid && m_wready;
    wl_hs = w_hs && m_wlast;
    b_hs  = m_bvalid && m_bready;
    pop   = din_valid && din_ready;
    if (fd_prev && chk_fall) check("busy_fall", busy, 0);
    fd_prev = frame_done;
    if (hold_aw) begin
      check("aw_stable_v", m_awvalid, 1);
      check("aw_stable_a", m_awaddr, h_addr);
    end
    if (hold_w && m_wvalid) check("w_stable", m_wdata, h_data);
    hold_aw = m_awvalid && !m_awready;
    h_addr  = m_awaddr;
    hold_w  = m_wvalid && !m_wready;
    h_data  = m_wdata;
    if (w_hs) begin
      check("w_after_aw", w_cnt < aw_cnt * 16, 1);
      check("wdata", m_wdata, exp_w.size() > 0 ? exp_w.pop_front() : 'x);
      check("wlast", m_wlast, w_cnt % 16 == 15);
      check("wstrb", m_wstrb, 8'hFF);
      w_cnt++;
    end
    if (aw_hs) begin
      if (aw_cnt == 0) first_aw = m_awaddr;
      check("awaddr", m_awaddr, mbase + 32'((aw_cnt % mfb) * 128));
      check("awlen", m_awlen, 15);
      aw_cnt++;
    end
    if (b_hs) begin
      check("frame_done", frame_done, (b_cnt + 1) % mfb == 0);
      b_cnt++;
    end else check("fd_quiet", frame_done, 0);
    fd_cnt += int'(frame_done);
    @(posedge fclk);
    #1;
    if (pop && fifo.size() > 0) void'(fifo.pop_front());
    if (b_hs) begin
      m_bvalid = 0;
      b_pend = 0;
    end
    if (wl_hs) b_pend = 1;
    if (b_pend && !m_bvalid && (!stall || $urandom_range(0, 1) == 1)) begin
      m_bvalid = 1;
      m_bresp = (b_cnt == bad_b) ? 2'b10 : 2'b00;
    end
    m_awready = !stall || $urandom_range(0, 1) == 1;
    m_wready  = !stall || $urandom_range(0, 2) != 0;
    if (drop > 0) drop--;
    if (drop_arm && w_cnt == 7) begin
      drop = 5;
      drop_arm = 0;
    end
    upd_in();
  endtask

  task automatic go(input logic [31:0] b, input int fb, input logic c);
    base_addr = b; frame_bursts = 20'(fb); cont = c;
    mbase = b & ~32'h7F; mfb = fb;
    start = 1;
    cycle();
    start = 0;
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      cycle();
      n++;
    end
    check("idle_reached", busy, 0);
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1;
    clr();
    repeat (2) @(posedge fclk);
    #1;
    check("rst_awvalid", m_awvalid, 0);
    check("rst_wvalid", m_wvalid, 0);
    check("rst_bready", m_bready, 0);
    check("rst_din_ready", din_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_awaddr", m_awaddr, 0);
    rst = 0;
    // 1: three bursts, ideal slave
    clr();
    chk_fall = 1;
    fill(48);
    go(32'h1000_0000, 3, 0);
    check("t1_busy", busy, 1);
    run_idle(400);
    check("t1_aw", aw_cnt, 3);
    check("t1_w", w_cnt, 48);
    check("t1_fd", fd_cnt, 1);
    check("t1_left", exp_w.size(), 0);
    // 2: misaligned base is rounded down
    clr();
    fill(16);
    go(32'h1000_0044, 1, 0);
    run_idle(200);
    check("t2_first_aw", first_aw, 32'h1000_0000);
    check("t2_w", w_cnt, 16);
    // 3: random slave stalls plus a FIFO underrun at beat 7
    clr();
    stall = 1;
    drop_arm = 1;
    fill(32);
    go($urandom, 2, 0);
    run_idle(3000);
    check("t3_aw", aw_cnt, 2);
    check("t3_w", w_cnt, 32);
    check("t3_fd", fd_cnt, 1);
    check("t3_left", exp_w.size(), 0);
    // 4: continuous mode, stop in the middle of the fifth burst
    clr();
    fill(80);
    go(32'h3000_0100, 2, 1);
    n = 0;
    while (w_cnt < 67 && n < 1000) begin
      cycle();
      n++;
    end
    check("t4_reach", w_cnt, 67);
    stop = 1;
    cycle();
    stop = 0;
    run_idle(500);
    check("t4_aw", aw_cnt, 5);
    check("t4_w", w_cnt, 80);
    check("t4_fd", fd_cnt, 2);
    fill(16);
    repeat (10) cycle();
    check("t4_no_aw", aw_cnt, 5);
    check("t4_idle", busy, 0);
    // 5: SLVERR on the first burst is sticky until the next start
    clr();
    bad_b = 0;
    fill(32);
    go(32'h4000_0000, 2, 0);
    run_idle(400);
    check("t5_err", err, 1);
    check("t5_w", w_cnt, 32);
    check("t5_b", b_cnt, 2);
    clr();
    fill(16);
    go(32'h4000_1000, 1, 0);
    check("t5_err_clr", err, 0);
    run_idle(200);
    check("t5_err_stay0", err, 0);
    // 6: reset in the middle of a burst, then start without burst_valid
    clr();
    fill(32);
    go(32'h5000_0000, 2, 0);
    n = 0;
    while (w_cnt < 5 && n < 200) begin
      cycle();
      n++;
    end
    rst = 1;
    cycle();
    check("t6_awvalid", m_awvalid, 0);
    check("t6_wvalid", m_wvalid, 0);
    check("t6_bready", m_bready, 0);
    check("t6_busy", busy, 0);
    check("t6_awaddr", m_awaddr, 0);
    rst = 0;
    clr();
    go(32'h6000_0000, 1, 0);
    repeat (10) cycle();
    check("t6_wait_busy", busy, 1);
    check("t6_no_aw", aw_cnt, 0);
    check("t6_awvalid_lo", m_awvalid, 0);
    fill(16);
    run_idle(200);
    check("t6_w", w_cnt, 16);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
